spi_reg_bridge: RTL

//  Byte-protocol controller sitting between spi_slave and the internal register bus.

---
 rtl/spi_reg_bridge.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: byte-protocol controller between spi_slave and the internal
// req/ack register bus. Decodes a command byte (bit7 = read, bits[6:0] = start
// address), issues one bus access per data byte and sequences the spi_slave TX
// holding register (status byte while idle, then read data).
//
// Build option: SPI_REG_BRIDGE_AUTOINC_EN
//   defined     -> address increments after every data byte (wraps at 2**ADDR_WIDTH)
//   not defined -> address stays at the command address for the whole burst
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | no transaction; push status byte when CS_n high and TX ready
// CMD     | waiting for command byte
// WR_DATA | waiting for next write data byte
// WR_BUS  | bus write outstanding (req=1, we=1) until ack or timeout
// RD_BUS  | bus read outstanding (req=1, we=0) until ack or timeout
// RD_PUSH | waiting for TX holding register to load read data
// RD_WAIT | waiting for shifter to take the byte (tx_ready 0->1), then prefetch

module spi_reg_bridge #(
    parameter int         ADDR_WIDTH = 7,
    parameter int         TIMEOUT    = 255,
    parameter logic [3:0] STATUS_ID  = 4'hA
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_cs_n,
    input  logic                  i_tx_ready,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [7:0]            o_bus_wdata,
    input  logic [7:0]            i_bus_rdata,
    input  logic                  i_bus_ack,
    output logic [1:0]            o_err,
    output logic                  o_active
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        WR_BUS,
        RD_BUS,
        RD_PUSH,
        RD_WAIT
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [7:0]            rdata_q;
    logic [TW-1:0]         timer;
    logic                  status_pend;
    logic                  cs_n_q;
    logic                  tx_ready_q;
    logic                  abort;
    logic                  bus_done;

    // Address advance after each data byte; fixed-address mode serves FIFO ports.
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    assign addr_next = addr + 1'b1;
`else
    assign addr_next = addr;
`endif

    // An access finishes on ack or when the down-counter reaches terminal count;
    // ack on the terminal cycle is treated as a normal completion.
    assign bus_done   = i_bus_ack || (timer == '0);
    assign o_bus_addr = addr;
    assign o_active   = (state != IDLE);

    // Transaction sequencer, bus handshake, TX push and sticky error tracking.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            addr        <= '0;
            rdata_q     <= 8'h00;
            timer       <= '0;
            status_pend <= 1'b1;
            cs_n_q      <= 1'b1;
            tx_ready_q  <= 1'b0;
            abort       <= 1'b0;
            o_tx_data   <= 8'h00;
            o_tx_valid  <= 1'b0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_wdata <= 8'h00;
            o_err       <= 2'b00;
        end else begin
            cs_n_q     <= i_cs_n;
            tx_ready_q <= i_tx_ready;
            o_tx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    abort <= 1'b0;
                    if (status_pend && i_cs_n && i_tx_ready) begin
                        o_tx_valid  <= 1'b1;
                        o_tx_data   <= {o_err, 2'b00, STATUS_ID};
                        status_pend <= 1'b0;
                    end
                    if (cs_n_q && !i_cs_n) begin
                        state <= CMD;
                    end
                end

                CMD: begin
                    if (i_cs_n) begin
                        state       <= IDLE;
                        status_pend <= 1'b1;
                    end else if (i_rx_valid) begin
                        addr  <= i_rx_data[ADDR_WIDTH-1:0];
                        o_err <= 2'b00;
                        if (i_rx_data[7]) begin
                            state     <= RD_BUS;
                            o_bus_req <= 1'b1;
                            o_bus_we  <= 1'b0;
                            timer     <= TW'(TIMEOUT - 1);
                        end else begin
                            state <= WR_DATA;
                        end
                    end
                end

                WR_DATA: begin
                    if (i_cs_n) begin
                        state       <= IDLE;
                        status_pend <= 1'b1;
                    end else if (i_rx_valid) begin
                        o_bus_wdata <= i_rx_data;
                        state       <= WR_BUS;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= 1'b1;
                        timer       <= TW'(TIMEOUT - 1);
                    end
                end

                WR_BUS: begin
                    // A byte arriving while the previous write is still pending is lost.
                    if (i_rx_valid) begin
                        o_err[1] <= 1'b1;
                    end
                    if (i_cs_n) begin
                        abort <= 1'b1;
                    end
                    if (bus_done) begin
                        o_bus_req <= 1'b0;
                        if (!i_bus_ack) begin
                            o_err[0] <= 1'b1;
                        end
                        addr <= addr_next;
                        if (abort || i_cs_n) begin
                            state       <= IDLE;
                            status_pend <= 1'b1;
                        end else begin
                            state <= WR_DATA;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                RD_BUS: begin
                    if (i_cs_n) begin
                        abort <= 1'b1;
                    end
                    if (bus_done) begin
                        o_bus_req <= 1'b0;
                        if (i_bus_ack) begin
                            rdata_q <= i_bus_rdata;
                        end else begin
                            rdata_q  <= 8'h00;
                            o_err[0] <= 1'b1;
                        end
                        if (abort || i_cs_n) begin
                            state       <= IDLE;
                            status_pend <= 1'b1;
                        end else begin
                            state <= RD_PUSH;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                RD_PUSH: begin
                    if (i_cs_n) begin
                        state       <= IDLE;
                        status_pend <= 1'b1;
                    end else if (i_tx_ready) begin
                        o_tx_valid <= 1'b1;
                        o_tx_data  <= rdata_q;
                        addr       <= addr_next;
                        state      <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    // tx_ready rising means the shifter took the byte: prefetch the next one.
                    if (i_cs_n) begin
                        state       <= IDLE;
                        status_pend <= 1'b1;
                    end else if (!tx_ready_q && i_tx_ready) begin
                        state     <= RD_BUS;
                        o_bus_req <= 1'b1;
                        o_bus_we  <= 1'b0;
                        timer     <= TW'(TIMEOUT - 1);
                    end
                end

                default: begin
                    state       <= IDLE;
                    status_pend <= 1'b1;
                    o_bus_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
